// File: rtl/fp_adder_seq_pkg.sv
// fp_adder_seq_pkg: shared floating-point field geometry, FSM state codes and operand classifier.
// Rev 1.0
`default_nettype none
package fp_adder_seq_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_class_t;

  function automatic int exp_msb(input int p);
    return p - 2;
  endfunction

  function automatic int man_msb(input int p);
    return (p == 64) ? 51 : 22;
  endfunction

  // Subnormals classify as zero: the datapath never produces or consumes them.
  function automatic fp_class_t classify(input logic [63:0] x, input int p);
    fp_class_t c;
    logic      exp_ones;
    logic      exp_zero;
    logic      frac_zero;
    if (p == 64) begin
      exp_ones  = &x[62:52];
      exp_zero  = ~|x[62:52];
      frac_zero = ~|x[51:0];
    end else begin
      exp_ones  = &x[30:23];
      exp_zero  = ~|x[30:23];
      frac_zero = ~|x[22:0];
    end
    c.nan  = exp_ones & ~frac_zero;
    c.inf  = exp_ones & frac_zero;
    c.zero = exp_zero;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_adder_seq_if.sv
// fp_adder_seq_if: Load/Op/A/B request and Result/Valid completion bundle of the adder.
// Rev 1.0
`default_nettype none
interface fp_adder_seq_if #(
  parameter int PRECISION = 32
);
  logic                 Enable;
  logic                 Load;
  logic                 Op;
  logic [PRECISION-1:0] A;
  logic [PRECISION-1:0] B;
  logic [PRECISION-1:0] Result;
  logic                 Valid;

  modport master (output Enable, Load, Op, A, B, input Result, Valid);
  modport slave  (input Enable, Load, Op, A, B, output Result, Valid);
endinterface
`default_nettype wire

// File: rtl/fp_adder_seq_lzc.sv
// fp_lzc: combinational leading-zero count; an all-zero input returns W.
// Rev 1.0
`default_nettype none
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_adder_seq.sv
// fp_adder_seq: multi-cycle IEEE-754 add/subtract (ALIGN, ADD, NORM, ROUND), RNE, subnormals flushed.
// Rev 1.0
`default_nettype none
module fp_adder_seq
  import fp_adder_seq_pkg::*;
#(
  parameter int PRECISION = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fp_adder_seq_if.slave bus
);

  localparam int EW  = exp_msb(PRECISION) - man_msb(PRECISION);
  localparam int FW  = man_msb(PRECISION) + 1;
  localparam int MW  = FW + 3;
  localparam int SW  = MW + 1;
  localparam int CW  = SW + 1;
  localparam int XW  = EW + 2;
  localparam int LZW = $clog2(SW + 1);

  localparam logic [PRECISION-1:0] C_NAN      = {1'b0, {(PRECISION-1){1'b1}}};
  localparam logic [EW-1:0]        C_MAX_SH   = EW'(MW - 1);
  localparam logic [XW-1:0]        C_EXP_ONES = XW'((1 << EW) - 1);

  logic [2:0]           state_q, state_d;
  logic [PRECISION-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [PRECISION-1:0] result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 sign_q, sign_d, sub_q, sub_d;
  logic                 stk_q, stk_d, zero_q, zero_d;
  logic [XW-1:0]        exp_q, exp_d;
  logic [MW-1:0]        xm_q, xm_d, ym_q, ym_d;
  logic [CW-1:0]        sum_q, sum_d;
  logic [SW-1:0]        nrm_q, nrm_d;

  fp_class_t            w_ca, w_cb;
  logic                 w_a_ge, w_spec, w_stk;
  logic [PRECISION-1:0] w_spec_res, w_x;
  logic [PRECISION-2:0] w_y;
  logic [EW-1:0]        w_diff;
  logic [MW-1:0]        w_ym_full, w_ym_sh;
  logic [LZW-1:0]       w_lzc;
  logic                 w_up;
  logic [FW+1:0]        w_mant;
  logic [XW-1:0]        w_exp_r;
  logic [FW-1:0]        w_frac_r;
  logic [PRECISION-1:0] w_packed;

  // ---------------- ALIGN: classify, order by magnitude, shift smaller operand
  assign w_ca      = classify(64'(opa_q), PRECISION);
  assign w_cb      = classify(64'(opb_q), PRECISION);
  assign w_a_ge    = opa_q[PRECISION-2:0] >= opb_q[PRECISION-2:0];
  assign w_x       = w_a_ge ? opa_q : opb_q;
  assign w_y       = w_a_ge ? opb_q[PRECISION-2:0] : opa_q[PRECISION-2:0];
  assign w_diff    = w_x[PRECISION-2:FW] - w_y[PRECISION-2:FW];
  assign w_ym_full = {1'b1, w_y[FW-1:0], 2'b00};

  always_comb begin
    if (w_diff > C_MAX_SH) begin
      w_ym_sh = '0;
      w_stk   = 1'b1;
    end else begin
      w_ym_sh = w_ym_full >> w_diff;
      w_stk   = |(w_ym_full & ~({MW{1'b1}} << w_diff));
    end
  end

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    if (w_ca.nan || w_cb.nan || (w_ca.inf && w_cb.inf && (opa_q[PRECISION-1] != opb_q[PRECISION-1])))
      w_spec_res = C_NAN;
    else if (w_ca.inf)
      w_spec_res = opa_q;
    else if (w_cb.inf)
      w_spec_res = opb_q;
    else if (w_ca.zero && w_cb.zero)
      w_spec_res = {opa_q[PRECISION-1] & opb_q[PRECISION-1], {(PRECISION-1){1'b0}}};
    else if (w_ca.zero)
      w_spec_res = opb_q;
    else if (w_cb.zero)
      w_spec_res = opa_q;
    else
      w_spec = 1'b0;
  end

  // ---------------- NORM: leading-zero count of the carry-free sum
  fp_lzc #(.W(SW), .CW(LZW)) u_lzc (
    .in_i  (sum_q[SW-1:0]),
    .cnt_o (w_lzc)
  );

  // ---------------- ROUND: RNE on guard / round / sticky, then range check
  assign w_up     = nrm_q[2] & (nrm_q[1] | nrm_q[0] | nrm_q[3]);
  assign w_mant   = {1'b0, nrm_q[SW-1:3]} + {{(FW+1){1'b0}}, w_up};
  assign w_exp_r  = exp_q + {{(XW-1){1'b0}}, w_mant[FW+1]};
  // On mantissa overflow the low bits are already zero and the hidden bit clears.
  assign w_frac_r = w_mant[FW-1:0] & {FW{w_mant[FW]}};

  always_comb begin
    if (zero_q)
      w_packed = '0;
    else if (w_exp_r[XW-1] || (w_exp_r == '0))
      w_packed = {sign_q, {(PRECISION-1){1'b0}}};
    else if (w_exp_r >= C_EXP_ONES)
      w_packed = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
    else
      w_packed = {sign_q, w_exp_r[EW-1:0], w_frac_r};
  end

  // ---------------- next-state
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    valid_d  = 1'b0;
    sign_d   = sign_q;
    sub_d    = sub_q;
    stk_d    = stk_q;
    zero_d   = zero_q;
    exp_d    = exp_q;
    xm_d     = xm_q;
    ym_d     = ym_q;
    sum_d    = sum_q;
    nrm_d    = nrm_q;
    if (bus.Load) begin
      opa_d   = bus.A;
      opb_d   = {bus.B[PRECISION-1] ^ bus.Op, bus.B[PRECISION-2:0]};
      state_d = S_ALIGN;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ALIGN: begin
          if (w_spec) begin
            result_d = w_spec_res;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
          end else begin
            sign_d  = w_x[PRECISION-1];
            sub_d   = opa_q[PRECISION-1] ^ opb_q[PRECISION-1];
            exp_d   = XW'(w_x[PRECISION-2:FW]);
            xm_d    = {1'b1, w_x[FW-1:0], 2'b00};
            ym_d    = w_ym_sh;
            stk_d   = w_stk;
            state_d = S_ADD;
          end
        end
        S_ADD: begin
          // Sticky rides as the subtrahend/addend LSB so RNE stays exact after subtraction.
          sum_d   = sub_q ? ({1'b0, xm_q, 1'b0} - {1'b0, ym_q, stk_q})
                          : ({1'b0, xm_q, 1'b0} + {1'b0, ym_q, stk_q});
          state_d = S_NORM;
        end
        S_NORM: begin
          zero_d = (sum_q == '0);
          if (sum_q[CW-1]) begin
            nrm_d = {sum_q[CW-1:2], sum_q[1] | sum_q[0]};
            exp_d = exp_q + XW'(1);
          end else begin
            nrm_d = sum_q[SW-1:0] << w_lzc;
            exp_d = exp_q - XW'(w_lzc);
          end
          state_d = S_ROUND;
        end
        S_ROUND: begin
          result_d = w_packed;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      stk_q    <= 1'b0;
      zero_q   <= 1'b0;
      exp_q    <= '0;
      xm_q     <= '0;
      ym_q     <= '0;
      sum_q    <= '0;
      nrm_q    <= '0;
    end else if (bus.Enable) begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      stk_q    <= stk_d;
      zero_q   <= zero_d;
      exp_q    <= exp_d;
      xm_q     <= xm_d;
      ym_q     <= ym_d;
      sum_q    <= sum_d;
      nrm_q    <= nrm_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Valid  = valid_q;

endmodule
`default_nettype wire
